ramb_asym_dp: RTL and testbench

RAMB_ASYM_DP -- requirements
Module: ramb_asym_dp

---
 rtl/ramb_asym_dp.sv | 182 ++++++++++++++++++
 tb/tb_ramb_asym_dp.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb_asym_dp.sv
// Asymmetric true dual-port block RAM: narrow port A and wide port B share one array.
// Per-port write modes, synchronous set/reset, optional output register and data-valid strobe.
module ramb_asym_dp #(
   parameter int unsigned                  A_WIDTH      = 4,
   parameter int unsigned                  RATIO        = 2,
   parameter int unsigned                  B_AW         = 11,
   parameter string                        WRITE_MODE_A = "WRITE_FIRST",
   parameter string                        WRITE_MODE_B = "WRITE_FIRST",
   parameter logic [A_WIDTH-1:0]           INIT_A       = '0,
   parameter logic [A_WIDTH*RATIO-1:0]     INIT_B       = '0,
   parameter logic [A_WIDTH-1:0]           SRVAL_A      = '0,
   parameter logic [A_WIDTH*RATIO-1:0]     SRVAL_B      = '0,
   parameter int unsigned                  DO_REG       = 0
) (
   input  logic                              CLK,
   input  logic                              RST_N,
   input  logic                              ENA,
   input  logic                              WEA,
   input  logic                              SSRA,
   input  logic [B_AW+$clog2(RATIO)-1:0]     ADDRA,
   input  logic [A_WIDTH-1:0]                DIA,
   output logic [A_WIDTH-1:0]                DOA,
   output logic                              DVA,
   input  logic                              ENB,
   input  logic                              WEB,
   input  logic                              SSRB,
   input  logic [B_AW-1:0]                   ADDRB,
   input  logic [A_WIDTH*RATIO-1:0]          DIB,
   output logic [A_WIDTH*RATIO-1:0]          DOB,
   output logic                              DVB
);

   localparam int unsigned LOG2R   = $clog2(RATIO);
   localparam int unsigned A_AW    = B_AW + LOG2R;
   localparam int unsigned B_WIDTH = A_WIDTH * RATIO;
   localparam int unsigned LANE_W  = (LOG2R > 0) ? LOG2R : 1;
   localparam int unsigned DEPTH   = 1 << B_AW;

   typedef enum logic [1:0] {
      WM_WRITE_FIRST,
      WM_READ_FIRST,
      WM_NO_CHANGE,
      WM_INVALID
   } wmode_e;

   localparam wmode_e MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
                               (WRITE_MODE_A == "READ_FIRST")  ? WM_READ_FIRST  :
                               (WRITE_MODE_A == "NO_CHANGE")   ? WM_NO_CHANGE   : WM_INVALID;
   localparam wmode_e MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
                               (WRITE_MODE_B == "READ_FIRST")  ? WM_READ_FIRST  :
                               (WRITE_MODE_B == "NO_CHANGE")   ? WM_NO_CHANGE   : WM_INVALID;

   if (MODE_A == WM_INVALID) begin : g_bad_mode_a
      $fatal(1, "ramb_asym_dp: illegal WRITE_MODE_A %s", WRITE_MODE_A);
   end
   if (MODE_B == WM_INVALID) begin : g_bad_mode_b
      $fatal(1, "ramb_asym_dp: illegal WRITE_MODE_B %s", WRITE_MODE_B);
   end
   if (RATIO != 1 && RATIO != 2 && RATIO != 4 && RATIO != 8) begin : g_bad_ratio
      $fatal(1, "ramb_asym_dp: illegal RATIO %0d", RATIO);
   end

   // 2-state storage so the array starts at zero without a reset sweep.
   bit   [B_WIDTH-1:0] mem_q [DEPTH];

   logic [B_AW-1:0]    a_word;
   logic [LANE_W-1:0]  a_lane;
   logic [B_WIDTH-1:0] word_a;
   logic [B_WIDTH-1:0] word_b;
   logic [A_WIDTH-1:0] rd_a;
   logic               wr_a;
   logic               wr_b;

   assign a_word = ADDRA[A_AW-1:LOG2R];

   if (LOG2R == 0) begin : g_single_lane
      assign a_lane = '0;
   end else begin : g_multi_lane
      assign a_lane = ADDRA[LOG2R-1:0];
   end

   assign word_a = mem_q[a_word];
   assign word_b = mem_q[ADDRB];
   assign rd_a   = word_a[a_lane*A_WIDTH +: A_WIDTH];
   assign wr_a   = ENA & WEA & RST_N;
   assign wr_b   = ENB & WEB & RST_N;

   // Port B is assigned last so it owns any lane both ports hit on the same edge.
   always_ff @(posedge CLK) begin
      if (wr_a) mem_q[a_word][a_lane*A_WIDTH +: A_WIDTH] <= DIA;
      if (wr_b) mem_q[ADDRB] <= DIB;
   end

   logic [A_WIDTH-1:0] doa_q, doa_d;
   logic               dva_q, dva_d;
   logic [B_WIDTH-1:0] dob_q, dob_d;
   logic               dvb_q, dvb_d;

   always_comb begin
      doa_d = doa_q;
      dva_d = 1'b0;
      if (ENA) begin
         if (SSRA) begin
            doa_d = SRVAL_A;
         end else if (!WEA) begin
            doa_d = rd_a;
            dva_d = 1'b1;
         end else begin
            case (MODE_A)
               WM_WRITE_FIRST: begin doa_d = DIA;  dva_d = 1'b1; end
               WM_READ_FIRST:  begin doa_d = rd_a; dva_d = 1'b1; end
               default:        ;
            endcase
         end
      end
   end

   always_comb begin
      dob_d = dob_q;
      dvb_d = 1'b0;
      if (ENB) begin
         if (SSRB) begin
            dob_d = SRVAL_B;
         end else if (!WEB) begin
            dob_d = word_b;
            dvb_d = 1'b1;
         end else begin
            case (MODE_B)
               WM_WRITE_FIRST: begin dob_d = DIB;    dvb_d = 1'b1; end
               WM_READ_FIRST:  begin dob_d = word_b; dvb_d = 1'b1; end
               default:        ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         doa_q <= INIT_A;
         dva_q <= 1'b0;
         dob_q <= INIT_B;
         dvb_q <= 1'b0;
      end else begin
         doa_q <= doa_d;
         dva_q <= dva_d;
         dob_q <= dob_d;
         dvb_q <= dvb_d;
      end
   end

   if (DO_REG != 0) begin : g_out_reg
      logic [A_WIDTH-1:0] doa2_q;
      logic               dva2_q;
      logic [B_WIDTH-1:0] dob2_q;
      logic               dvb2_q;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            doa2_q <= INIT_A;
            dva2_q <= 1'b0;
            dob2_q <= INIT_B;
            dvb2_q <= 1'b0;
         end else begin
            doa2_q <= doa_q;
            dva2_q <= dva_q;
            dob2_q <= dob_q;
            dvb2_q <= dvb_q;
         end
      end

      assign DOA = doa2_q;
      assign DVA = dva2_q;
      assign DOB = dob2_q;
      assign DVB = dvb2_q;
   end else begin : g_out_direct
      assign DOA = doa_q;
      assign DVA = dva_q;
      assign DOB = dob_q;
      assign DVB = dvb_q;
   end

endmodule

// File: tb/tb_ramb_asym_dp.sv
// Bench for ramb_asym_dp: two differently configured instances share stimulus and are
// compared every cycle against a byte-array memory model plus directed constant checks.
module tb_ramb_asym_dp;

   logic        CLK;
   logic        RST_N;
   logic        ENA, WEA, SSRA;
   logic [11:0] ADDRA;
   logic [3:0]  DIA;
   logic        ENB, WEB, SSRB;
   logic [10:0] ADDRB;
   logic [7:0]  DIB;

   logic [3:0]  doa0, doa1;
   logic        dva0, dva1;
   logic [7:0]  dob0, dob1;
   logic        dvb0, dvb1;

   int n_cmp;
   int n_err;

   ramb_asym_dp #(
      .A_WIDTH(4), .RATIO(2), .B_AW(11),
      .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
      .INIT_A(4'h0), .INIT_B(8'hEE), .SRVAL_A(4'h9), .SRVAL_B(8'h00),
      .DO_REG(0)
   ) u_dut0 (
      .CLK(CLK), .RST_N(RST_N),
      .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa0), .DVA(dva0),
      .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob0), .DVB(dvb0)
   );

   ramb_asym_dp #(
      .A_WIDTH(4), .RATIO(2), .B_AW(11),
      .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"),
      .INIT_A(4'h3), .INIT_B(8'h11), .SRVAL_A(4'h6), .SRVAL_B(8'h5C),
      .DO_REG(1)
   ) u_dut1 (
      .CLK(CLK), .RST_N(RST_N),
      .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa1), .DVA(dva1),
      .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob1), .DVB(dvb1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- reference model ----------------
   localparam logic [3:0] INIT_A_M  [2] = '{4'h0, 4'h3};
   localparam logic [7:0] INIT_B_M  [2] = '{8'hEE, 8'h11};
   localparam logic [3:0] SRVAL_A_M [2] = '{4'h9, 4'h6};
   localparam logic [7:0] SRVAL_B_M [2] = '{8'h00, 8'h5C};
   localparam int         DO_REG_M  [2] = '{0, 1};

   string      mode_a [2];
   string      mode_b [2];
   logic [7:0] mem_m  [2048];
   logic [3:0] s1a [2], s2a [2];
   logic       s1va[2], s2va[2];
   logic [7:0] s1b [2], s2b [2];
   logic       s1vb[2], s2vb[2];

   task automatic model_init();
      mode_a[0] = "WRITE_FIRST"; mode_b[0] = "READ_FIRST";
      mode_a[1] = "NO_CHANGE";   mode_b[1] = "WRITE_FIRST";
      foreach (mem_m[i]) mem_m[i] = 8'h00;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         s1a[k] = INIT_A_M[k]; s2a[k] = INIT_A_M[k];
         s1b[k] = INIT_B_M[k]; s2b[k] = INIT_B_M[k];
         s1va[k] = 1'b0; s2va[k] = 1'b0;
         s1vb[k] = 1'b0; s2vb[k] = 1'b0;
      end
   endtask

   // One rising edge: reads see pre-edge memory, then A writes its nibble, then B its byte.
   task automatic model_edge();
      logic [7:0] wa, wb;
      logic [3:0] ra;
      if (RST_N !== 1'b1) return;
      wa = mem_m[ADDRA[11:1]];
      ra = ADDRA[0] ? wa[7:4] : wa[3:0];
      wb = mem_m[ADDRB];
      for (int k = 0; k < 2; k++) begin
         s2a[k] = s1a[k]; s2va[k] = s1va[k];
         s2b[k] = s1b[k]; s2vb[k] = s1vb[k];
         s1va[k] = 1'b0;
         s1vb[k] = 1'b0;
         if (ENA) begin
            if (SSRA) s1a[k] = SRVAL_A_M[k];
            else if (!WEA) begin s1a[k] = ra; s1va[k] = 1'b1; end
            else if (mode_a[k] == "WRITE_FIRST") begin s1a[k] = DIA; s1va[k] = 1'b1; end
            else if (mode_a[k] == "READ_FIRST")  begin s1a[k] = ra;  s1va[k] = 1'b1; end
         end
         if (ENB) begin
            if (SSRB) s1b[k] = SRVAL_B_M[k];
            else if (!WEB) begin s1b[k] = wb; s1vb[k] = 1'b1; end
            else if (mode_b[k] == "WRITE_FIRST") begin s1b[k] = DIB; s1vb[k] = 1'b1; end
            else if (mode_b[k] == "READ_FIRST")  begin s1b[k] = wb;  s1vb[k] = 1'b1; end
         end
      end
      if (ENA && WEA) begin
         if (ADDRA[0]) mem_m[ADDRA[11:1]][7:4] = DIA;
         else          mem_m[ADDRA[11:1]][3:0] = DIA;
      end
      if (ENB && WEB) mem_m[ADDRB] = DIB;
   endtask

   function automatic logic [27:0] exp_vec();
      logic [27:0] v;
      for (int k = 0; k < 2; k++) begin
         if (DO_REG_M[k] != 0) v[(1-k)*14 +: 14] = {s2a[k], s2va[k], s2b[k], s2vb[k]};
         else                  v[(1-k)*14 +: 14] = {s1a[k], s1va[k], s1b[k], s1vb[k]};
      end
      return v;
   endfunction

   function automatic logic [27:0] obs_vec();
      return {doa0, dva0, dob0, dvb0, doa1, dva1, dob1, dvb1};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      ENA = 1'b0; WEA = 1'b0; SSRA = 1'b0;
      ENB = 1'b0; WEB = 1'b0; SSRB = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      ADDRA = '0; DIA = '0; ADDRB = '0; DIB = '0;
      RST_N = 1'b1;
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({doa0, dva0, dob0, dvb0, doa1, dva1, dob1, dvb1} !== {4'h0, 1'b0, 8'hEE, 1'b0, 4'h3, 1'b0, 8'h11, 1'b0}) begin
         n_err++;
         $display("FAIL reset_values actual=%h required=%h", obs_vec(), {4'h0, 1'b0, 8'hEE, 1'b0, 4'h3, 1'b0, 8'h11, 1'b0});
      end
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_hold actual=%h required=%h", obs_vec(), exp_vec());
         end
      end
      RST_N = 1'b1;
   endtask

   task automatic test_lane_map();
      idle(); ENA = 1'b1; WEA = 1'b1; ADDRA = 12'h001; DIA = 4'h5;
      step();
      ADDRA = 12'h000; DIA = 4'hA;
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL lane_write actual=%h required=%h", obs_vec(), exp_vec());
      end
      idle(); ENB = 1'b1; ADDRB = 11'h000;
      step();
      n_cmp++;
      if ({dob0, dvb0} !== {8'h5A, 1'b1}) begin
         n_err++;
         $display("FAIL lane_read_b actual=%h required=%h", {dob0, dvb0}, {8'h5A, 1'b1});
      end
      idle();
      step();
      n_cmp++;
      if ({dvb0, dob1, dvb1} !== {1'b0, 8'h5A, 1'b1}) begin
         n_err++;
         $display("FAIL lane_read_pulse actual=%h required=%h", {dvb0, dob1, dvb1}, {1'b0, 8'h5A, 1'b1});
      end
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL lane_model actual=%h required=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_read_first();
      idle(); ENB = 1'b1; WEB = 1'b1; ADDRB = 11'h010; DIB = 8'h33;
      step();
      DIB = 8'hC4;
      step();
      n_cmp++;
      if ({dob0, dvb0} !== {8'h33, 1'b1}) begin
         n_err++;
         $display("FAIL read_first_old actual=%h required=%h", {dob0, dvb0}, {8'h33, 1'b1});
      end
      WEB = 1'b0;
      step();
      n_cmp++;
      if (dob0 !== 8'hC4) begin
         n_err++;
         $display("FAIL read_first_new actual=%h required=%h", dob0, 8'hC4);
      end
      idle();
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL read_first_model actual=%h required=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_collision();
      idle();
      ENA = 1'b1; WEA = 1'b1; ADDRA = 12'h021; DIA = 4'hF;
      ENB = 1'b1; WEB = 1'b1; ADDRB = 11'h010; DIB = 8'h12;
      step();
      n_cmp++;
      if (doa0 !== 4'hF) begin
         n_err++;
         $display("FAIL collide_own_di actual=%h required=%h", doa0, 4'hF);
      end
      idle(); ENA = 1'b1; ADDRA = 12'h021; ENB = 1'b1; ADDRB = 11'h010;
      step();
      n_cmp++;
      if ({dob0, doa0} !== {8'h12, 4'h1}) begin
         n_err++;
         $display("FAIL collide_b_wins actual=%h required=%h", {dob0, doa0}, {8'h12, 4'h1});
      end
      ADDRA = 12'h020; WEB = 1'b1; DIB = 8'h77;
      step();
      n_cmp++;
      if (doa0 !== 4'h2) begin
         n_err++;
         $display("FAIL read_during_write actual=%h required=%h", doa0, 4'h2);
      end
      idle();
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL collide_model actual=%h required=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_ssr();
      idle(); ENA = 1'b1; ADDRA = 12'h021;
      step();
      n_cmp++;
      if (doa0 !== 4'h7) begin
         n_err++;
         $display("FAIL ssr_pre_read actual=%h required=%h", doa0, 4'h7);
      end
      ENA = 1'b0; SSRA = 1'b1;
      step();
      n_cmp++;
      if ({doa0, dva0} !== {4'h7, 1'b0}) begin
         n_err++;
         $display("FAIL ssr_disabled actual=%h required=%h", {doa0, dva0}, {4'h7, 1'b0});
      end
      ENA = 1'b1; WEA = 1'b1; ADDRA = 12'h030; DIA = 4'h6;
      ENB = 1'b1; SSRB = 1'b1; ADDRB = 11'h018;
      step();
      n_cmp++;
      if ({doa0, dva0} !== {4'h9, 1'b0}) begin
         n_err++;
         $display("FAIL ssr_srval actual=%h required=%h", {doa0, dva0}, {4'h9, 1'b0});
      end
      idle(); ENA = 1'b1;
      step();
      n_cmp++;
      if ({doa0, dva0} !== {4'h6, 1'b1}) begin
         n_err++;
         $display("FAIL ssr_write_kept actual=%h required=%h", {doa0, dva0}, {4'h6, 1'b1});
      end
      idle();
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL ssr_model actual=%h required=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] want [3];
      want[0] = 8'h5A; want[1] = 8'h77; want[2] = 8'h06;
      idle(); ENB = 1'b1; ADDRB = 11'h000;
      step();
      n_cmp++;
      if (dvb1 !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_latency actual=%h required=%h", dvb1, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         if (i == 0) ADDRB = 11'h010;
         else if (i == 1) ADDRB = 11'h018;
         else idle();
         step();
         n_cmp++;
         if ({dob1, dvb1} !== {want[i], 1'b1}) begin
            n_err++;
            $display("FAIL b2b_pulse%0d actual=%h required=%h", i, {dob1, dvb1}, {want[i], 1'b1});
         end
      end
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec() || dvb1 !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_end actual=%h required=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_mid_read();
      idle(); ENB = 1'b1; ADDRB = 11'h010;
      step();
      idle();
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({dob0, dvb0, dob1, dvb1} !== {8'hEE, 1'b0, 8'h11, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset actual=%h required=%h", {dob0, dvb0, dob1, dvb1}, {8'hEE, 1'b0, 8'h11, 1'b0});
      end
      ENA = 1'b1; WEA = 1'b1; ADDRA = 12'h021; DIA = 4'h0;
      ENB = 1'b1; WEB = 1'b1; ADDRB = 11'h010; DIB = 8'h00;
      step();
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_no_write actual=%h required=%h", obs_vec(), exp_vec());
      end
      idle();
      RST_N = 1'b1;
      step();
      n_cmp++;
      if ({dvb0, dvb1} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_discard actual=%b required=%b", {dvb0, dvb1}, 2'b00);
      end
      ENB = 1'b1; ADDRB = 11'h010;
      step();
      n_cmp++;
      if ({dob0, dvb0} !== {8'h77, 1'b1}) begin
         n_err++;
         $display("FAIL reset_preserve actual=%h required=%h", {dob0, dvb0}, {8'h77, 1'b1});
      end
      idle();
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_preserve_model actual=%h required=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            idle();
            #2;
            RST_N = 1'b0;
            model_reset();
            #1;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_err++;
               $display("FAIL rand_reset cyc=%0d actual=%h required=%h", i, obs_vec(), exp_vec());
            end
            step();
            RST_N = 1'b1;
         end
         ENA   = ($urandom_range(0, 3) != 0);
         WEA   = 1'($urandom_range(0, 1));
         SSRA  = ($urandom_range(0, 7) == 0);
         ADDRA = 12'($urandom_range(0, 31));
         DIA   = 4'($urandom);
         ENB   = ($urandom_range(0, 3) != 0);
         WEB   = 1'($urandom_range(0, 1));
         SSRB  = ($urandom_range(0, 7) == 0);
         ADDRB = 11'($urandom_range(0, 15));
         DIB   = 8'($urandom);
         step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL rand_cycle cyc=%0d actual=%h required=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      model_init();
      model_reset();
      test_reset();
      test_lane_map();
      test_read_first();
      test_collision();
      test_ssr();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
